// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types and helpers for the pixel scan sequencer.
//   state_t    : frame sequencer states
//   N_PIX_DEF  : default photodiode count
//   next_pix() : next scan index, stepping over the reference pixel
//   clamp1()   : treats a zero cycle count as one cycle
package pixel_seq_pkg;

  localparam int N_PIX_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    RST_PD,
    INTEG,
    REF_SEL,
    REF_HOLD,
    PIX_SEL,
    PIX_LATCH,
    DONE
  } state_t;

  function automatic int next_pix(int index, int ref_idx);
    int n;
    n = index + 1;
    if (n == ref_idx) n = n + 1;
    return n;
  endfunction

  function automatic int clamp1(int n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/pixel_scan_sequencer_if.sv
// Control/status bus between the Wishbone register block and the sequencer.
//   start/abort      : frame request and abort (register block -> sequencer)
//   cfg_*_cyc        : phase durations, captured at start acceptance
//   busy/done        : frame status
//   lbp_code         : last completed local-binary-pattern code
// master = register block side, slave = sequencer side.
interface pixel_scan_sequencer_if
  import pixel_seq_pkg::*;
#(
  parameter int N_PIX = N_PIX_DEF,
  parameter int TW    = 16
) ();
  logic             start;
  logic             abort;
  logic [7:0]       cfg_rst_cyc;
  logic [TW-1:0]    cfg_int_cyc;
  logic [7:0]       cfg_settle_cyc;
  logic             busy;
  logic             done;
  logic [N_PIX-1:0] lbp_code;

  modport master (
    output start, abort, cfg_rst_cyc, cfg_int_cyc, cfg_settle_cyc,
    input  busy, done, lbp_code
  );

  modport slave (
    input  start, abort, cfg_rst_cyc, cfg_int_cyc, cfg_settle_cyc,
    output busy, done, lbp_code
  );
endinterface

// File: rtl/pixel_scan_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous analog-domain signals.
//   clk : destination clock
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
  end

  assign q = sync_p1;
endmodule

// File: rtl/pixel_scan_sequencer.sv
// Frame sequencer for the photodiode analog front end.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus                : start/abort/config in, busy/done/lbp_code out
//   cmp_in             : asynchronous comparator decision
//   pd_a, pd_b         : per-pixel readout-bus and reset switches
//   sh_rst, sh, sh_cmp : sample-and-hold controls
// Every output is a register loaded from the next-state decode, so the
// switch pattern lines up exactly with the state it belongs to.
module pixel_scan_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int N_PIX   = N_PIX_DEF,
  parameter int REF_IDX = 0,
  parameter int TW      = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  pixel_scan_sequencer_if.slave  bus,
  input  logic                   cmp_in,
  output logic [N_PIX-1:0]       pd_a,
  output logic [N_PIX-1:0]       pd_b,
  output logic                   sh_rst,
  output logic                   sh,
  output logic                   sh_cmp
);
  localparam int PW        = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int FIRST_PIX = (REF_IDX == 0) ? 1 : 0;
  localparam int LAST_PIX  = (REF_IDX == N_PIX - 1) ? N_PIX - 2 : N_PIX - 1;

  state_t           state, state_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [PW-1:0]    pix, pix_nxt;
  logic [TW-1:0]    int_cyc;
  logic [7:0]       settle_cyc;
  logic [N_PIX-1:0] code_shadow, code_nxt, pix_mask;
  logic [N_PIX-1:0] pd_a_nxt, pd_b_nxt;
  logic             sh_rst_nxt, sh_nxt, sh_cmp_nxt;
  logic             start_ok, tmr_done, cmp_sync;

  sync_2ff #(.WIDTH(1)) u_cmp_sync (
    .clk (wb_clk_i),
    .d   (cmp_in),
    .q   (cmp_sync)
  );

  always_comb begin
    state_nxt = state;
    pix_nxt   = pix;
    start_ok  = (state == IDLE) && bus.start && !bus.abort;
    tmr_done  = (tmr == TW'(1));
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (bus.start) state_nxt = RST_PD;
        RST_PD:    if (tmr_done) state_nxt = INTEG;
        INTEG:     if (tmr_done) state_nxt = REF_SEL;
        REF_SEL:   if (tmr_done) state_nxt = REF_HOLD;
        REF_HOLD: begin
          state_nxt = PIX_SEL;
          pix_nxt   = PW'(FIRST_PIX);
        end
        PIX_SEL:   if (tmr_done) state_nxt = PIX_LATCH;
        PIX_LATCH: begin
          if (pix == PW'(LAST_PIX)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = PIX_SEL;
            pix_nxt   = PW'(next_pix(int'(pix), REF_IDX));
          end
        end
        DONE:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Timer is reloaded on every state entry; the RST_PD load reads the
  // config straight off the bus, which is its capture point.
  always_comb begin
    tmr_nxt = (tmr != '0) ? tmr - TW'(1) : '0;
    if (state_nxt != state) begin
      case (state_nxt)
        RST_PD:           tmr_nxt = TW'(clamp1(int'(bus.cfg_rst_cyc)));
        INTEG:            tmr_nxt = TW'(clamp1(int'(int_cyc)));
        REF_SEL, PIX_SEL: tmr_nxt = TW'(clamp1(int'(settle_cyc)));
        default:          ;
      endcase
    end
  end

  // The final pixel is latched on the same edge that enters DONE, so the
  // published code merges it in here rather than waiting a cycle.
  always_comb begin
    pix_mask = N_PIX'(1) << pix;
    code_nxt = code_shadow;
    if (state == PIX_LATCH)
      code_nxt = (code_shadow & ~pix_mask) | (cmp_sync ? pix_mask : '0);
  end

  always_comb begin
    pd_a_nxt   = '0;
    pd_b_nxt   = '0;
    sh_rst_nxt = 1'b0;
    sh_nxt     = 1'b0;
    sh_cmp_nxt = 1'b0;
    case (state_nxt)
      RST_PD: begin
        pd_b_nxt   = '1;
        sh_rst_nxt = 1'b1;
      end
      REF_SEL: begin
        pd_a_nxt = N_PIX'(1) << REF_IDX;
        sh_nxt   = 1'b1;
      end
      PIX_SEL: begin
        pd_a_nxt   = N_PIX'(1) << pix_nxt;
        sh_cmp_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      tmr          <= '0;
      pix          <= '0;
      pd_a         <= '0;
      pd_b         <= '0;
      sh_rst       <= 1'b0;
      sh           <= 1'b0;
      sh_cmp       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.lbp_code <= '0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      pix      <= pix_nxt;
      pd_a     <= pd_a_nxt;
      pd_b     <= pd_b_nxt;
      sh_rst   <= sh_rst_nxt;
      sh       <= sh_nxt;
      sh_cmp   <= sh_cmp_nxt;
      bus.busy <= (state_nxt != IDLE);
      bus.done <= (state_nxt == DONE);
      if (state_nxt == DONE)
        bus.lbp_code <= code_nxt & ~(N_PIX'(1) << REF_IDX);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    code_shadow <= code_nxt;
    if (start_ok) begin
      int_cyc    <= bus.cfg_int_cyc;
      settle_cyc <= bus.cfg_settle_cyc;
    end
  end
endmodule

// File: tb/tb_pixel_scan_sequencer.sv
module tb_pixel_scan_sequencer;
  localparam int NP  = 12;
  localparam int TWL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_scan_sequencer_if #(.N_PIX(NP), .TW(TWL)) bus_a ();
  pixel_scan_sequencer_if #(.N_PIX(NP), .TW(TWL)) bus_b ();

  logic [NP-1:0] pd_a_a, pd_b_a, pd_a_b, pd_b_b;
  logic          sh_rst_a, sh_a, sh_cmp_a, sh_rst_b, sh_b, sh_cmp_b;
  logic          cmp_a, cmp_b;
  logic [NP-1:0] pattern = '0;

  // Comparator model: reads high while a pixel selected in 'pattern' is on the bus.
  assign cmp_a = |(pd_a_a & pattern);
  assign cmp_b = 1'b1;

  pixel_scan_sequencer #(.N_PIX(NP), .REF_IDX(0), .TW(TWL)) dut_a (
    .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus_a), .cmp_in (cmp_a),
    .pd_a (pd_a_a), .pd_b (pd_b_a), .sh_rst (sh_rst_a), .sh (sh_a), .sh_cmp (sh_cmp_a)
  );

  pixel_scan_sequencer #(.N_PIX(NP), .REF_IDX(11), .TW(TWL)) dut_b (
    .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus_b), .cmp_in (cmp_b),
    .pd_a (pd_a_b), .pd_b (pd_b_b), .sh_rst (sh_rst_b), .sh (sh_b), .sh_cmp (sh_cmp_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int busy_a_tot = 0, done_a_tot = 0, done_a_at = 0, viol_a = 0;
  int done_b_tot = 0, viol_b = 0, ref11_cyc = 0;

  always @(negedge clk) begin
    if (bus_a.busy) busy_a_tot++;
    if (bus_a.done) begin
      done_a_tot++;
      done_a_at = busy_a_tot;
    end
    if ($countones(pd_a_a) > 1 || (pd_a_a != '0 && pd_b_a != '0) ||
        ((sh_a || sh_cmp_a) && $countones(pd_a_a) != 1)) viol_a++;
    if ($countones(pd_a_b) > 1 || (pd_a_b != '0 && pd_b_b != '0) ||
        ((sh_b || sh_cmp_b) && $countones(pd_a_b) != 1)) viol_b++;
    if (pd_a_b[11]) begin
      ref11_cyc++;
      if (!sh_b) viol_b++;
    end
    if (bus_b.done) done_b_tot++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_a(logic [7:0] r, logic [15:0] i, logic [7:0] s);
    bus_a.cfg_rst_cyc    = r;
    bus_a.cfg_int_cyc    = i;
    bus_a.cfg_settle_cyc = s;
  endtask

  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(int budget, string tag);
    int k = 0;
    while (!bus_a.done && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_reached_done"}, 32'(bus_a.done), 32'd1);
  endtask

  int b0, d0, r0, k;

  initial begin
    bus_a.start = 1'b0; bus_a.abort = 1'b0; cfg_a(8'd0, 16'd0, 8'd0);
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    bus_b.cfg_rst_cyc = 8'd2; bus_b.cfg_int_cyc = 16'd3; bus_b.cfg_settle_cyc = 8'd2;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    check("reset_lbp", 32'(bus_a.lbp_code), 32'h0);
    check("reset_switches", {8'd0, pd_a_a, pd_b_a}, 32'd0);
    check("reset_sh", {29'd0, sh_rst_a, sh_a, sh_cmp_a}, 32'd0);

    // Nominal frame: odd pixels compare high.
    cfg_a(8'd4, 16'd10, 8'd3); pattern = 12'hAAA;
    b0 = busy_a_tot; d0 = done_a_tot;
    pulse_start_a();
    check("nom_first_busy", 32'(bus_a.busy), 32'd1);
    check("nom_rst_pd", {19'd0, sh_rst_a, pd_b_a}, {19'd0, 1'b1, 12'hFFF});
    wait_done_a(200, "nom");
    check("nom_lbp", 32'(bus_a.lbp_code), 32'hAAA);
    tick();
    check("nom_busy_after", 32'(bus_a.busy), 32'd0);
    check("nom_done_count", 32'(done_a_tot - d0), 32'd1);
    check("nom_frame_len", 32'(busy_a_tot - b0), 32'd63);
    check("nom_done_pos", 32'(done_a_at - b0), 32'd63);

    // Zero configuration: every timed phase collapses to one cycle.
    cfg_a(8'd0, 16'd0, 8'd0); pattern = 12'h000;
    b0 = busy_a_tot;
    pulse_start_a();
    wait_done_a(100, "zero");
    check("zero_lbp", 32'(bus_a.lbp_code), 32'h0);
    tick();
    check("zero_frame_len", 32'(busy_a_tot - b0), 32'd27);

    // Different timing and pattern.
    cfg_a(8'd2, 16'd5, 8'd3); pattern = 12'h5A4;
    b0 = busy_a_tot;
    pulse_start_a();
    wait_done_a(200, "mix");
    check("mix_lbp", 32'(bus_a.lbp_code), 32'h5A4);
    tick();
    check("mix_frame_len", 32'(busy_a_tot - b0), 32'd56);

    // Abort while pixel 5 is selected.
    cfg_a(8'd4, 16'd10, 8'd3); pattern = 12'h0F0;
    d0 = done_a_tot;
    pulse_start_a();
    k = 0;
    while (!(pd_a_a[5] && sh_cmp_a) && k < 200) begin
      tick();
      k++;
    end
    check("abort_reached_pix5", 32'(pd_a_a[5] && sh_cmp_a), 32'd1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    check("abort_switches", {8'd0, pd_a_a, pd_b_a}, 32'd0);
    check("abort_sh_cmp", 32'(sh_cmp_a), 32'd0);
    check("abort_lbp_kept", 32'(bus_a.lbp_code), 32'h5A4);
    tick(80);
    check("abort_no_done", 32'(done_a_tot - d0), 32'd0);
    b0 = busy_a_tot;
    pulse_start_a();
    wait_done_a(200, "post_abort");
    check("post_abort_lbp", 32'(bus_a.lbp_code), 32'h0F0);
    tick();
    check("post_abort_len", 32'(busy_a_tot - b0), 32'd63);

    // start pulses while busy are dropped.
    b0 = busy_a_tot; d0 = done_a_tot;
    pulse_start_a();
    tick(10);
    pulse_start_a();
    tick(30);
    pulse_start_a();
    wait_done_a(200, "busy_start");
    tick();
    check("busy_start_len", 32'(busy_a_tot - b0), 32'd63);
    tick(80);
    check("busy_start_frames", 32'(done_a_tot - d0), 32'd1);
    check("busy_start_idle", 32'(bus_a.busy), 32'd0);

    // start and abort together in IDLE.
    b0 = busy_a_tot; d0 = done_a_tot;
    bus_a.start = 1'b1; bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    check("start_abort_busy", 32'(bus_a.busy), 32'd0);
    tick(20);
    check("start_abort_frames", 32'(done_a_tot - d0), 32'd0);
    check("start_abort_cycles", 32'(busy_a_tot - b0), 32'd0);

    // Reference at the top index, comparator held high.
    r0 = ref11_cyc; d0 = done_b_tot;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    k = 0;
    while (!bus_b.done && k < 200) begin
      tick();
      k++;
    end
    check("ref11_reached_done", 32'(bus_b.done), 32'd1);
    check("ref11_lbp", 32'(bus_b.lbp_code), 32'h7FF);
    tick();
    check("ref11_done_count", 32'(done_b_tot - d0), 32'd1);
    check("ref11_pd_a11_cycles", 32'(ref11_cyc - r0), 32'd2);

    // Reset in the middle of a frame.
    pulse_start_a();
    tick(20);
    check("midrst_busy_before", 32'(bus_a.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_lbp", 32'(bus_a.lbp_code), 32'h0);
    check("midrst_switches", {8'd0, pd_a_a, pd_b_a}, 32'd0);
    check("midrst_ctrl", {28'd0, sh_rst_a, sh_a, sh_cmp_a, bus_a.done}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("midrst_after_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_after_lbp", 32'(bus_a.lbp_code), 32'h0);

    check("switch_rules_a", 32'(viol_a), 32'd0);
    check("switch_rules_b", 32'(viol_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pixel_scan_sequencer.md
Name: pixel_scan_sequencer

Overview:
- Digital sequencer for the 12-photodiode analog front end: per-pixel reset/readout switches, sample-and-hold and comparator-sample controls.
- Runs one full frame: global reset, integration, reference-pixel sample, then compares each remaining pixel against the reference.
- Packs the comparator decisions into an N_PIX-bit local-binary-pattern code.
- Sits beside the Wishbone register block, which provides start/abort and timing configuration and reads back the code.

Parameters:
- N_PIX, 12, number of photodiodes scanned.
- REF_IDX, 0, index of the reference (centre) pixel; its code bit is always 0.
- TW, 16, width of the phase timer and of the integration-time config.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start  in  1  single-cycle frame request; ignored while busy.
- abort  in  1  synchronous frame abort.
- cfg_rst_cyc  in  8  photodiode reset duration in cycles; 0 is treated as 1.
- cfg_int_cyc  in  TW  integration duration in cycles; 0 is treated as 1.
- cfg_settle_cyc  in  8  settle time after each switch change; 0 is treated as 1.
- cmp_in  in  1  asynchronous comparator output from the analog block.
- pd_a  out  N_PIX  per-pixel readout-bus switch, one-hot or zero.
- pd_b  out  N_PIX  per-pixel reset switch.
- sh_rst  out  1  sample-and-hold reset.
- sh  out  1  reference sample-and-hold control.
- sh_cmp  out  1  comparator-input sample control.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when the code is valid.
- lbp_code  out  N_PIX  last completed code; holds until the next done.

Behaviour:
- All outputs are registered. Reset value of every output, including lbp_code, is 0. Reset state is IDLE.
- Configuration inputs are captured on start acceptance and held constant for the whole frame.
- cmp_in passes through a 2-flop synchronizer. Latched values therefore reflect cmp_in from 2 cycles earlier; the settle time covers this.
- One TW-bit down-counter `tmr` is loaded on entry to each timed state. The state exits in the cycle `tmr`==1. A config of n therefore gives exactly max(n,1) cycles in that state.

State machine:
- IDLE: all outputs 0 except lbp_code. start=1 -> RST_PD.
- RST_PD: pd_b = all ones, sh_rst=1, for cfg_rst_cyc cycles -> INTEG.
- INTEG: all switches open, for cfg_int_cyc cycles -> REF_SEL.
- REF_SEL: pd_a[REF_IDX]=1, sh=1, for cfg_settle_cyc cycles -> REF_HOLD.
- REF_HOLD: 1 cycle. pd_a=0 and sh=0, giving break-before-make. Set pix to the first index not equal to REF_IDX, then go to PIX_SEL.
- PIX_SEL: pd_a[pix]=1, sh_cmp=1, for cfg_settle_cyc cycles -> PIX_LATCH.
- PIX_LATCH: 1 cycle. code_shadow[pix] <= synchronized cmp. pd_a=0, sh_cmp=0.
  - If pix is the last non-reference index -> DONE.
  - Otherwise advance pix, skipping REF_IDX, -> PIX_SEL.
- DONE: 1 cycle. lbp_code <= code_shadow with bit REF_IDX forced to 0. done=1 -> IDLE.

Boundary conditions:
- pd_a is never multi-hot. pd_a and pd_b are never both non-zero in the same cycle.
- pix counter wraps only by returning to IDLE. REF_IDX = N_PIX-1 ends the scan at index N_PIX-2.
- abort in any non-IDLE state: next cycle is IDLE, all switches 0, busy=0, no done, lbp_code unchanged. abort has priority over every state transition.
- start and abort in the same cycle while in IDLE: abort wins, and the frame does not start.
- start while busy: ignored, with no queuing.
- wb_rst_i mid-frame: identical to reset; lbp_code clears to 0.
- Frame length = max(r,1) + max(i,1) + N_PIX·(max(s,1)+1) + 1 cycles, where r/i/s are the captured cfg values.

Decomposition:
- Shared package pixel_seq_pkg holds:
  - the state enum;
  - N_PIX_DEF = 12;
  - a next_pix(index, ref) helper returning the next index, skipping ref.
- One sub-module: sync_2ff, a parameterisable-width two-flop synchronizer, used for cmp_in and reusable for other analog-to-digital crossings.

Test Plan:
- Reset/idle: assert wb_rst_i for 3 cycles mid-frame -> every output 0 next cycle, busy=0, lbp_code=0.
- Nominal frame: cfg rst=4, int=10, settle=3; cmp_in driven high for odd pixels only.
  - lbp_code=12'hAAA.
  - done exactly 4+10+12·4+1 = 63 cycles after the first busy cycle.
  - Exactly one pd_a bit high whenever sh or sh_cmp is high.
- Zero config: all cfg=0 -> each timed phase lasts exactly 1 cycle; frame length 4+12·2-... checked against the formula: 1+1+24+1 = 27 cycles.
- REF_IDX=11 build: cmp_in=1 throughout -> lbp_code=12'h7FF, and pd_a[11] is asserted only during REF_SEL.
- Abort during PIX_SEL of pixel 5 -> IDLE next cycle, no done, lbp_code keeps the previous frame value; a subsequent start runs a full correct frame.
- start pulsed while busy, and start+abort together in IDLE -> neither starts a frame, and the frame count is unchanged.
